// File: rtl/cache_line_read_port.sv
// L1 cache CPU read port: returns one word of a 128-bit line, using a one-entry
// line buffer invalidated by write snoops. Optional feature macro: BYTE_EXTRACT_EN.
module cache_line_read_port #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [1:0]        mem_byte_enable,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              line_read,
  output logic [ADDR_W-5:0] line_address,
  input  logic              line_resp,
  input  logic [LINE_W-1:0] line_rdata,
  input  logic              wr_strobe,
  input  logic [ADDR_W-1:0] wr_address
);
  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [2:0] off);
    word_sel = line[int'(off)*WORD_W +: WORD_W];
  endfunction

`ifdef BYTE_EXTRACT_EN
  function automatic logic [WORD_W-1:0] byte_shape(input logic [WORD_W-1:0] word,
                                                   input logic [1:0] be);
    case (be)
      2'b01:   byte_shape = {{(WORD_W-8){1'b0}}, word[7:0]};
      2'b10:   byte_shape = {{(WORD_W-8){1'b0}}, word[15:8]};
      default: byte_shape = word;
    endcase
  endfunction
`endif

  state_t            state_r, state_s;
  logic [LINE_W-1:0] buf_line_r, buf_line_s;
  logic [TAG_W-1:0]  buf_tag_r, buf_tag_s;
  logic              buf_valid_r, buf_valid_s;
  logic [2:0]        req_off_r, req_off_s;
  logic [1:0]        req_be_r, req_be_s;
  logic [WORD_W-1:0] rdata_s, hit_data_s, fill_data_s;
  logic              resp_s, line_read_s;
  logic [TAG_W-1:0]  line_address_s;
  logic              snoop_buf_s, snoop_fill_s, hit_s;
  logic              unused_s;

  // A snoop on the buffered line blocks a hit in the same cycle; a snoop on the
  // line being filled leaves the freshly captured buffer invalid.
  assign snoop_buf_s  = wr_strobe && (wr_address[ADDR_W-1:4] == buf_tag_r);
  assign snoop_fill_s = wr_strobe && (wr_address[ADDR_W-1:4] == line_address);
  assign hit_s        = buf_valid_r && (buf_tag_r == mem_address[ADDR_W-1:4]) && !snoop_buf_s;

`ifdef BYTE_EXTRACT_EN
  assign hit_data_s  = byte_shape(word_sel(buf_line_r, mem_address[3:1]), mem_byte_enable);
  assign fill_data_s = byte_shape(word_sel(line_rdata, req_off_r), req_be_r);
`else
  assign hit_data_s  = word_sel(buf_line_r, mem_address[3:1]);
  assign fill_data_s = word_sel(line_rdata, req_off_r);
`endif

  assign unused_s = ^{mem_address[0], wr_address[3:0], req_be_r, mem_byte_enable};

  // Next-state and next-output logic for the IDLE/FILL/RESP controller.
  always_comb begin
    state_s        = state_r;
    buf_line_s     = buf_line_r;
    buf_tag_s      = buf_tag_r;
    buf_valid_s    = buf_valid_r && !snoop_buf_s;
    req_off_s      = req_off_r;
    req_be_s       = req_be_r;
    rdata_s        = mem_rdata;
    resp_s         = 1'b0;
    line_read_s    = 1'b0;
    line_address_s = line_address;
    case (state_r)
      IDLE: begin
        if (mem_read) begin
          req_off_s = mem_address[3:1];
          req_be_s  = mem_byte_enable;
          if (hit_s) begin
            rdata_s = hit_data_s;
            resp_s  = 1'b1;
            state_s = RESP;
          end else begin
            line_address_s = mem_address[ADDR_W-1:4];
            line_read_s    = 1'b1;
            state_s        = FILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (line_resp) begin
          buf_line_s  = line_rdata;
          buf_tag_s   = line_address;
          buf_valid_s = !snoop_fill_s;
          rdata_s     = fill_data_s;
          resp_s      = 1'b1;
          state_s     = RESP;
        end else begin
          line_read_s = 1'b1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, buffer and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      buf_line_r   <= {LINE_W{1'b0}};
      buf_tag_r    <= {TAG_W{1'b0}};
      buf_valid_r  <= 1'b0;
      req_off_r    <= 3'd0;
      req_be_r     <= 2'b00;
      mem_rdata    <= {WORD_W{1'b0}};
      mem_resp     <= 1'b0;
      line_read    <= 1'b0;
      line_address <= {TAG_W{1'b0}};
    end else begin
      state_r      <= state_s;
      buf_line_r   <= buf_line_s;
      buf_tag_r    <= buf_tag_s;
      buf_valid_r  <= buf_valid_s;
      req_off_r    <= req_off_s;
      req_be_r     <= req_be_s;
      mem_rdata    <= rdata_s;
      mem_resp     <= resp_s;
      line_read    <= line_read_s;
      line_address <= line_address_s;
    end
  end

endmodule

// File: doc/cache_line_read_port.md
Name: cache_line_read_port

Overview:
- CPU-side read path of the L1 cache. It is the read-side counterpart of the byte/word write-merge path.
- On `mem_read` it returns the 16-bit word addressed by `mem_address`, taken from a 128-bit cache line.
- A one-entry line buffer serves repeat reads to the same line without touching the data array.
- A write snoop from the write-merge path invalidates the buffer, so stale data is never returned.

Parameters:
- ADDR_W, 16, byte address width.
- WORD_W, 16, CPU word width.
- LINE_W, 128, cache line width: 8 words, so offset bits are `[3:1]` and the tag is `[ADDR_W-1:4]`.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held high until `mem_resp`
- mem_address  in  ADDR_W  CPU byte address
- mem_byte_enable  in  2  lane select, used only with BYTE_EXTRACT_EN
- mem_rdata  out  WORD_W  read data; valid while `mem_resp`=1
- mem_resp  out  1  one-cycle completion pulse
- line_read  out  1  line request to the data array
- line_address  out  ADDR_W-4  line index requested (`mem_address[15:4]`, latched)
- line_resp  in  1  array has `line_rdata` valid this cycle
- line_rdata  in  LINE_W  returned line
- wr_strobe  in  1  a cache write is committing this cycle
- wr_address  in  ADDR_W  address of that write

Behaviour:
- Reset values: `mem_resp`=0, `mem_rdata`=0, `line_read`=0, `line_address`=0, buffer valid=0, state=IDLE.
- Reset is honoured in any state, including mid-FILL: `line_read` is low the cycle after reset.
- State registers: `buf_line` (LINE_W), `buf_tag` (ADDR_W-4), `buf_valid`, `req_off` (3 bits), `req_be` (2 bits).
- FSM states: IDLE, FILL, RESP.
- IDLE, with `mem_read`=1:
  - Latch `req_off` = `mem_address[3:1]` and `req_be`.
  - If `buf_valid` && `buf_tag`==`mem_address[15:4]` && !(`wr_strobe` && `wr_address[15:4]`==`buf_tag`): hit. Load `mem_rdata` from `buf_line` and go to RESP.
  - Otherwise: miss. Latch `line_address`=`mem_address[15:4]` and go to FILL.
- FILL:
  - `line_read`=1 and `line_address` is held stable.
  - When `line_resp`=1: capture `line_rdata` into `buf_line`, set `buf_tag`=`line_address`, set `buf_valid`=1, load `mem_rdata` from `line_rdata`, and go to RESP.
  - `line_read` deasserts on the next cycle.
- RESP:
  - `mem_resp`=1 for exactly one cycle, then IDLE.
  - `mem_read` is ignored in RESP. A new request is accepted in the following IDLE cycle.
- Word select: `mem_rdata` = `line[16*off+15 : 16*off]`, with off = 0 at line bits `[15:0]` and off = 7 at `[127:112]`.
- Latency:
  - Hit: `mem_read` sampled at cycle 0, `mem_resp` at cycle 1. Back-to-back hits complete every 2 cycles.
  - Miss: `mem_resp` the cycle after `line_resp`.
- `mem_rdata` is registered. It holds its value after `mem_resp` until the next load.
- Snoop rule: when `wr_strobe`=1 and `wr_address[15:4]`==`buf_tag`, `buf_valid`←0 at the next edge, in any state.
  - Snoop in the same cycle as the FILL capture of the same line: the response still returns the captured data, but `buf_valid` ends at 0 (snoop wins).
  - Snoop to a different tag has no effect.
- `line_resp` while in IDLE or RESP is ignored.
- `mem_read` dropped mid-FILL is a protocol violation; the FILL still completes and its response is issued.

Optional Feature:
- Macro: BYTE_EXTRACT_EN.
- When defined, RESP data is shaped by `req_be`:
  - 2'b01 → {8'h00, low byte of word}.
  - 2'b10 → {8'h00, high byte of word}.
  - 2'b11 or 2'b00 → full word.
- When undefined, `mem_byte_enable` is unused and the full word is always returned (the CPU datapath extracts bytes).

Test Plan:
1. Reset, then `mem_read` at 0x1236 with the array returning line {0x7777,…,0x1111,0x0000} (word k = 0x1111·k) 3 cycles after `line_read` → `line_read`=1 with `line_address`=0x123; `mem_resp` 1 cycle after `line_resp`; `mem_rdata`=0x3333.
2. Immediately read 0x123E → no `line_read`; `mem_resp` 1 cycle after the request; `mem_rdata`=0x7777.
3. `wr_strobe` with `wr_address`=0x1230, then read 0x1230 → miss, `line_read`=1; new line word0=0xBEEF returned as `mem_rdata`=0xBEEF. `wr_address`=0x4560 instead → hit, no `line_read`.
4. Hit request coincident with snoop to 0x1232 → treated as miss (FILL). Snoop coincident with the FILL `line_resp` → data still returned; next read of the same line misses again.
5. Assert `reset` 1 cycle into FILL → next cycle `line_read`=0, `mem_resp`=0. A late `line_resp` is ignored, and the next read of the same line misses.
6. BYTE_EXTRACT_EN defined, line word2=0xA5C3: read 0x1234 with be=01 → 0x00C3; be=10 → 0x00A5; be=11 → 0xA5C3. Undefined: all three → 0xA5C3.
